// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  // Indexed by {row, col}; entry 15 (r3/c3) is listed first.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-numbered low row wins when several rows are pulled down together.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd3;
    if (!rows[2]) r = 2'd2;
    if (!rows[1]) r = 2'd1;
    if (!rows[0]) r = 2'd0;
    return r;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - 4-bit two-flop synchroniser, resets to all-ones (rows idle high)
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column scanner with debounced press/release detection for a 4x4 keypad
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);

  logic [3:0]    rows_s;
  logic [PW-1:0] prescaler;
  logic          tick;

  state_t        state, state_nxt;
  logic [1:0]    col_sel, col_sel_nxt;
  logic [1:0]    cand_row, cand_row_nxt;
  logic [3:0]    cand_code, cand_code_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_code_nxt;
  logic          key_valid_nxt;
  logic          confirm;
  logic [1:0]    pick_row;
  logic          any_low;
  logic          cand_low;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rows_s)
  );

  assign tick     = (prescaler == PS_LAST);
  assign any_low  = ~&rows_s;
  assign pick_row = first_low(rows_s);
  assign cand_low = ~rows_s[cand_row];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Everything below only moves on a tick; between ticks the defaults hold state.
  always_comb begin
    state_nxt     = state;
    col_sel_nxt   = col_sel;
    cand_row_nxt  = cand_row;
    cand_code_nxt = cand_code;
    cnt_nxt       = cnt;
    key_code_nxt  = key_code;
    key_valid_nxt = key_valid;
    confirm       = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_row_nxt  = pick_row;
            cand_code_nxt = KEY_MAP[{pick_row, col_sel}];
            cnt_nxt       = '0;
            state_nxt     = DEBOUNCE;
          end else begin
            col_sel_nxt = col_sel + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CNT_DONE) begin
              state_nxt     = HELD;
              key_code_nxt  = cand_code;
              key_valid_nxt = 1'b1;
              confirm       = 1'b1;
            end
          end else begin
            state_nxt   = SCAN;
            col_sel_nxt = col_sel + 2'd1;
          end
        end
        HELD: begin
          if (!cand_low) begin
            cnt_nxt   = '0;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CNT_DONE) begin
              key_valid_nxt = 1'b0;
              state_nxt     = SCAN;
              col_sel_nxt   = col_sel + 2'd1;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      col_sel     <= 2'd0;
      col_n       <= COL_IDLE;
      cand_row    <= 2'd0;
      cand_code   <= 4'h0;
      cnt         <= '0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_sel     <= col_sel_nxt;
      col_n       <= ~(4'b0001 << col_sel_nxt);
      cand_row    <= cand_row_nxt;
      cand_code   <= cand_code_nxt;
      cnt         <= cnt_nxt;
      key_code    <= key_code_nxt;
      key_valid   <= key_valid_nxt;
      key_pressed <= confirm;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with an emulated 4x4 key matrix
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys;

  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key at {r,c} pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_valid(input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (key_valid !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {3'b0, key_valid}, {3'b0, v});
  endtask

  task automatic wait_col(input int c, input string name);
    logic [3:0] tgt;
    int n;
    tgt = 4'b0001 << c;
    tgt = ~tgt;
    n = 0;
    while (col_n == tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (col_n != tgt && n < 80) begin
      @(negedge clk);
      n++;
    end
    check(name, col_n, tgt);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending presses want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops an expected code on every strobe, and polices strobe/code invariants.
  initial begin
    logic [3:0] last_code;
    logic [3:0] e;
    logic       prev_p;
    last_code = 4'h0;
    prev_p    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_code = key_code;
        prev_p    = 1'b0;
      end else begin
        if (key_pressed) begin
          check("strobe_repeat", {3'b0, prev_p}, 4'h0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_press got code %h want no press", key_code);
          end else begin
            e = exp_q.pop_front();
            check("press_code", key_code, e);
          end
        end
        if (key_code != last_code) check("code_change_strobe", {3'b0, key_pressed}, 4'h1);
        last_code = key_code;
        prev_p    = key_pressed;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_col;
    rst  = 1'b1;
    keys = 16'h0;
    #12;
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_flags", {2'b0, key_valid, key_pressed}, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle scan
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      exp_col = 4'b0001 << ((k / 4) % 4);
      exp_col = ~exp_col;
      check("scan_col", col_n, exp_col);
      check("idle_flags", {2'b0, key_valid, key_pressed}, 4'h0);
    end

    // 2: r1/c2 -> 6, valid drops 3 ticks after release is seen
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_valid(1'b1, 120, "t2_valid_rise");
    repeat (8) @(negedge clk);
    keys = 16'h0;
    repeat (15) @(negedge clk);
    check("t2_valid_hold", {3'b0, key_valid}, 4'h1);
    @(negedge clk);
    check("t2_valid_drop", {3'b0, key_valid}, 4'h0);
    check("t2_code_kept", key_code, 4'h6);
    wait_drain(4, "t2_drain");

    // 3: press bounce on r0/c0
    wait_col(0, "t3_col0");
    keys = 16'h0001;
    repeat (8) @(negedge clk);
    keys = 16'h0;
    repeat (4) @(negedge clk);
    keys = 16'h0001;
    exp_q.push_back(4'h1);
    wait_drain(120, "t3_press");
    keys = 16'h0;
    wait_valid(1'b0, 120, "t3_release");
    check("t3_code_kept", key_code, 4'h1);

    // 4: release bounce on r3/c1
    keys = 16'h2000;
    exp_q.push_back(4'h0);
    wait_valid(1'b1, 120, "t4_valid_rise");
    keys = 16'h0;
    repeat (4) @(negedge clk);
    keys = 16'h2000;
    repeat (4) @(negedge clk);
    check("t4_bounce_held", {3'b0, key_valid}, 4'h1);
    keys = 16'h0;
    repeat (15) @(negedge clk);
    check("t4_valid_hold", {3'b0, key_valid}, 4'h1);
    @(negedge clk);
    check("t4_valid_drop", {3'b0, key_valid}, 4'h0);
    check("t4_code_kept", key_code, 4'h0);
    wait_drain(4, "t4_drain");

    // 5: r0+r3 on c3 -> A; later r2/c0 press is ignored while held
    keys = 16'h8008;
    exp_q.push_back(4'hA);
    wait_drain(120, "t5_press");
    keys = 16'h8108;
    repeat (48) @(negedge clk);
    check("t5_still_valid", {3'b0, key_valid}, 4'h1);
    check("t5_code", key_code, 4'hA);
    keys = 16'h0;
    wait_valid(1'b0, 120, "t5_release");

    // 6: reset mid-DEBOUNCE and mid-HELD with r1/c2 held throughout
    wait_col(2, "t6_col2");
    keys = 16'h0040;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6a_col", col_n, 4'b1110);
    check("t6a_code", key_code, 4'h0);
    check("t6a_valid", {3'b0, key_valid}, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'h6);
    wait_drain(120, "t6a_redetect");
    repeat (5) @(negedge clk);
    check("t6b_pre_valid", {3'b0, key_valid}, 4'h1);
    #1 rst = 1'b1;
    #1;
    check("t6b_col", col_n, 4'b1110);
    check("t6b_code", key_code, 4'h0);
    check("t6b_valid", {3'b0, key_valid}, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'h6);
    wait_drain(120, "t6b_redetect");
    keys = 16'h0;
    wait_valid(1'b0, 120, "t6_release");

    repeat (8) @(negedge clk);
    check("final_queue", exp_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
